// File: rtl/mux_lut_selfcheck.sv
// 2**N-entry lookup table with a registered functional read path and a
// self-check sweep that compares every entry against a golden reduce function.
// Optional feature: define MUX_LUT_SELFCHECK_FAIL_IDX_EN to add the fail_idx output.
module mux_lut_selfcheck #(
  parameter int N = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_vld,
  input  logic [2**N-1:0] cfg_tbl,
  output logic            cfg_rdy,
  input  logic [1:0]      op,
  input  logic            start,
  input  logic [N-1:0]    lut_in,
  output logic            lut_out,
  output logic            busy,
  output logic            done,
  output logic            fail
`ifdef MUX_LUT_SELFCHECK_FAIL_IDX_EN
  ,
  output logic [N-1:0]    fail_idx
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    REPORT
  } state_t;

  localparam logic [N-1:0] IDX_MAX = {N{1'b1}};

  // Pure 2:1 mux tree: level k halves the candidate set using select bit k.
  function automatic logic mux_tree(input logic [2**N-1:0] tbl, input logic [N-1:0] sel);
    logic [2**N-1:0] lvl;
    lvl = tbl;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < ((2**N) >> (k + 1)); j++) begin
        lvl[j] = sel[k] ? lvl[2*j+1] : lvl[2*j];
      end
    end
    return lvl[0];
  endfunction

  function automatic logic golden(input logic [1:0] f, input logic [N-1:0] v);
    logic g;
    case (f)
      2'd0:    g = ~v[0];
      2'd1:    g = &v;
      2'd2:    g = |v;
      2'd3:    g = ^v;
      default: g = 1'b0;
    endcase
    return g;
  endfunction

  state_t         state_r;
  logic [2**N-1:0] tbl_r;
  logic [N-1:0]   idx_r;
  logic [1:0]     op_r;
  logic           cfg_rdy_r;
  logic           busy_r;
  logic           done_r;
  logic           fail_r;
  logic           lut_out_r;
  logic           load_s;
  logic           miss_s;
`ifdef MUX_LUT_SELFCHECK_FAIL_IDX_EN
  logic [N-1:0]   fail_idx_r;
`endif

  assign load_s = cfg_vld & cfg_rdy_r;
  assign miss_s = mux_tree(tbl_r, idx_r) != golden(op_r, idx_r);

  // Truth-table register: loads only when the handshake completes
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_r <= {(2**N){1'b0}};
    end else if (load_s) begin
      tbl_r <= cfg_tbl;
    end else begin
      tbl_r <= tbl_r;
    end
  end

  // Functional read path, live in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_out_r <= 1'b0;
    end else begin
      lut_out_r <= mux_tree(tbl_r, lut_in);
    end
  end

  // Sweep controller with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= {N{1'b0}};
      op_r       <= 2'd0;
      cfg_rdy_r  <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      fail_r     <= 1'b0;
`ifdef MUX_LUT_SELFCHECK_FAIL_IDX_EN
      fail_idx_r <= {N{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r    <= SWEEP;
            op_r       <= op;
            idx_r      <= {N{1'b0}};
            fail_r     <= 1'b0;
            busy_r     <= 1'b1;
            cfg_rdy_r  <= 1'b0;
`ifdef MUX_LUT_SELFCHECK_FAIL_IDX_EN
            fail_idx_r <= {N{1'b0}};
`endif
          end else begin
            busy_r    <= 1'b0;
            cfg_rdy_r <= 1'b1;
          end
        end
        SWEEP: begin
          if (miss_s) begin
            fail_r <= 1'b1;
`ifdef MUX_LUT_SELFCHECK_FAIL_IDX_EN
            // Only the first mismatch of the sweep is recorded
            if (!fail_r) begin
              fail_idx_r <= idx_r;
            end else begin
              fail_idx_r <= fail_idx_r;
            end
`endif
          end else begin
            fail_r <= fail_r;
          end
          if (idx_r == IDX_MAX) begin
            state_r <= REPORT;
            idx_r   <= {N{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            idx_r   <= idx_r + N'(1'b1);
          end
        end
        REPORT: begin
          state_r   <= IDLE;
          done_r    <= 1'b0;
          cfg_rdy_r <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          idx_r     <= {N{1'b0}};
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          cfg_rdy_r <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_rdy  = cfg_rdy_r;
  assign lut_out  = lut_out_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign fail     = fail_r;
`ifdef MUX_LUT_SELFCHECK_FAIL_IDX_EN
  assign fail_idx = fail_idx_r;
`endif

endmodule

// File: doc/mux_lut_selfcheck.md
MUX_LUT_SELFCHECK -- requirements
Module: mux_lut_selfcheck

Interface
REQ-001 Parameter: N, default 2, number of LUT select inputs, legal range 1..6.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset; synchronous, active-high.
REQ-004 Port: cfg_vld  in  1  truth-table load request.
REQ-005 Port: cfg_tbl  in  2**N  truth table; bit i is the output for select value i.
REQ-006 Port: cfg_rdy  out  1  table load accepted this cycle when high with cfg_vld.
REQ-007 Port: op  in  2  golden function for self-check: 0 INV(sel[0]), 1 AND-reduce, 2 OR-reduce, 3 XOR-reduce.
REQ-008 Port: start  in  1  self-check sweep request.
REQ-009 Port: lut_in  in  N  functional select vector.
REQ-010 Port: lut_out  out  1  registered functional LUT output.
REQ-011 Port: busy  out  1  high while a sweep is in progress.
REQ-012 Port: done  out  1  single-cycle pulse at sweep completion.
REQ-013 Port: fail  out  1  sticky mismatch flag of the most recent sweep.

Function
REQ-014 Both LUT evaluation paths (functional and sweep) are trees of 2:1 multiplexers only, 2**N-1 muxes each; level k is selected by select bit k; no other logic operators in the tree.
REQ-015 Table register loads cfg_tbl on an edge where cfg_vld and cfg_rdy are both high; otherwise holds.
REQ-016 cfg_rdy is high only in state IDLE; cfg_vld while cfg_rdy is low is ignored with no side effect.
REQ-017 lut_out equals table[lut_in] registered, one-cycle latency, updating every cycle in every state, including during a sweep.
REQ-018 FSM states: IDLE, SWEEP, REPORT.
REQ-019 IDLE: start high -> SWEEP; the same edge latches op, clears fail, and sets idx (N bits) to 0.
REQ-020 SWEEP: each cycle compares table[idx] against golden(op, idx); a mismatch sets fail on that edge; idx then increments.
REQ-021 SWEEP: when idx == 2**N-1 and its compare completes -> REPORT; idx wraps to 0.
REQ-022 REPORT: done high for exactly that one cycle -> IDLE.
REQ-023 Latency: with start accepted at edge 0, busy is high for 2**N cycles, and done is high in the cycle following edge 2**N.
REQ-024 busy is high exactly in SWEEP; fail holds its value in IDLE and REPORT until the next accepted start.
REQ-025 start outside IDLE is ignored, with no restart and no latching.
REQ-026 cfg_vld and start both high in IDLE: the table loads and the sweep starts on the same edge; the sweep evaluates the newly loaded table.
REQ-027 op changes during SWEEP have no effect; the latched op is used.

Reset
REQ-028 rst high at an edge forces state IDLE, table 0, idx 0, lut_out 0, fail 0, done 0, busy 0.
REQ-029 rst during SWEEP aborts the sweep; no done pulse follows; fail reads 0 on the next cycle.
REQ-030 rst overrides simultaneous cfg_vld and start.

Configuration
REQ-031 Macro MUX_LUT_SELFCHECK_FAIL_IDX_EN defined: adds output fail_idx (N bits), which captures idx at the first mismatch of a sweep, is cleared to 0 on accepted start and on reset, and holds afterwards.
REQ-032 Macro MUX_LUT_SELFCHECK_FAIL_IDX_EN undefined: fail_idx port and its register are absent; all other behaviour is identical.

Verification
REQ-033 N=2, load 4'b1000, op=1, start -> busy for 4 cycles, done pulses once, fail=0.
REQ-034 N=2, load 4'b1000, op=3, start -> fail=1 at done; fail_idx=1 when MUX_LUT_SELFCHECK_FAIL_IDX_EN is defined.
REQ-035 N=2, load 4'b0110, lut_in=2'b10 -> lut_out=1 one cycle later; lut_in=2'b11 -> lut_out=0.
REQ-036 N=2, rst asserted in the second SWEEP cycle -> busy=0, fail=0, no done, cfg_rdy=1 next cycle.
REQ-037 N=2, cfg_vld with 4'b1111 during SWEEP -> cfg_rdy=0, table unchanged, sweep result unaffected.
REQ-038 N=3, load 8'h96, op=3, start together with cfg_vld -> busy for 8 cycles, done pulses once, fail=0.
